// File: rtl/apb_requester.sv
// APB4 requester: turns single-beat valid/ready commands into SETUP/ACCESS transfers, one at a time.
// Optional ACCESS-phase timeout abort is enabled by defining APB_REQ_TIMEOUT_EN.
module apb_requester #(
    parameter int APB_AW         = 12,
    parameter int APB_DW         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [APB_AW-1:0]   req_addr,
    input  logic [APB_DW-1:0]   req_wdata,
    input  logic [APB_DW/8-1:0] req_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [APB_DW-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic [APB_AW-1:0]   PADDR,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [APB_DW-1:0]   PWDATA,
    output logic [APB_DW/8-1:0] PSTRB,
    input  logic [APB_DW-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);
    localparam int SW = APB_DW / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [APB_AW-1:0] paddr_q, paddr_d;
    logic [APB_DW-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0]     pstrb_q, pstrb_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [APB_DW-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_REQ_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 32) ? 32 : CW_RAW);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_hit;

    assign to_hit = (cnt_q + CW'(1)) == TO_LIM;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP)
            cnt_d = '0;
        else if (state_q == ACCESS && !PREADY)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                state_d   = SETUP;
                psel_d    = 1'b1;
                penable_d = 1'b0;
                pwrite_d  = req_write;
                paddr_d   = req_addr;
                pwdata_d  = req_write ? req_wdata : '0;
                pstrb_d   = req_write ? req_strb  : '0;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // PREADY takes priority over a timeout expiring in the same cycle
                if (PREADY) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end
`ifdef APB_REQ_TIMEOUT_EN
                else if (to_hit) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
`endif
            end
            RESP: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = (state_q != IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule
